// File: rtl/ir_key_ctrl_if.sv
// Frame input bundle for ir_key_ctrl: decoded NEC frame plus its strobe.
// Handshake: i_frame_vld is a single-cycle strobe and i_frame is valid in that
// same cycle. There is no ready signal and no backpressure. A strobe that
// arrives while the consumer is busy is dropped by the consumer, not held.
interface ir_key_ctrl_if;
  logic        i_frame_vld;
  logic [31:0] i_frame;

  modport master (output i_frame_vld, output i_frame);
  modport slave  (input  i_frame_vld, input  i_frame);
endinterface

// File: rtl/ir_key_ctrl.sv
// ir_key_ctrl: validates decoded NEC IR frames, maps the command to a key and
// drives a six-digit BCD entry buffer. ENTER commits the buffer to o_value.
// Optional feature macro: IR_KEY_TIMEOUT_EN enables an idle auto-clear of the
// entry buffer after TIMEOUT_CYC cycles without an executed key.
module ir_key_ctrl #(
  parameter logic [7:0]  CUSTOM_CODE = 8'h00,
  parameter logic [31:0] TIMEOUT_CYC = 32'd250_000_000
) (
  input  logic         clk,
  input  logic         rst,
  ir_key_ctrl_if.slave frame_if,
  output logic [23:0]  o_digits,
  output logic [5:0]   o_dp,
  output logic         o_key_vld,
  output logic [3:0]   o_key,
  output logic [23:0]  o_value,
  output logic         o_enter,
  output logic [7:0]   o_err_cnt,
  output logic [7:0]   o_drop_cnt,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [3:0] KEY_BS    = 4'd10;
  localparam logic [3:0] KEY_CLR   = 4'd11;
  localparam logic [3:0] KEY_ENTER = 4'd12;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] frame_q;
  logic [3:0]  key_q;
  logic [2:0]  n;
  logic [3:0]  key_dec;
  logic        key_ok;
  logic        accept;
  logic        timeout_hit;

  assign dbg_state = state;

  // Command byte to key code; key_ok low for unmapped commands.
  always_comb begin
    key_dec = 4'd0;
    key_ok  = 1'b1;
    case (frame_q[15:8])
      8'h16: key_dec = 4'd0;
      8'h0C: key_dec = 4'd1;
      8'h18: key_dec = 4'd2;
      8'h5E: key_dec = 4'd3;
      8'h08: key_dec = 4'd4;
      8'h1C: key_dec = 4'd5;
      8'h5A: key_dec = 4'd6;
      8'h42: key_dec = 4'd7;
      8'h52: key_dec = 4'd8;
      8'h4A: key_dec = 4'd9;
      8'h44: key_dec = KEY_BS;
      8'h40: key_dec = KEY_CLR;
      8'h43: key_dec = KEY_ENTER;
      default: key_ok = 1'b0;
    endcase
  end

  assign accept = (frame_q[31:24] == CUSTOM_CODE) &&
                  ((frame_q[31:24] ^ frame_q[23:16]) == 8'hFF) &&
                  ((frame_q[15:8] ^ frame_q[7:0]) == 8'hFF) &&
                  key_ok;

  // Next-state logic: capture, validate, execute, back to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_if.i_frame_vld) state_nxt = CHECK;
      CHECK:   state_nxt = accept ? EXEC : IDLE;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Frame capture in IDLE and key latch in CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= 32'd0;
      key_q   <= 4'd0;
    end else begin
      if (state == IDLE && frame_if.i_frame_vld) frame_q <= frame_if.i_frame;
      if (state == CHECK) key_q <= key_dec;
    end
  end

  // Saturating reject and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_err_cnt  <= 8'd0;
      o_drop_cnt <= 8'd0;
    end else begin
      if (state == CHECK && !accept && o_err_cnt != 8'hFF)
        o_err_cnt <= o_err_cnt + 8'd1;
      if (state != IDLE && frame_if.i_frame_vld && o_drop_cnt != 8'hFF)
        o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

`ifdef IR_KEY_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // An executed key always wins over a coincident auto-clear.
  assign timeout_hit = (idle_cnt == TIMEOUT_CYC) && (n != 3'd0) && (state != EXEC);

  // Idle counter: cleared by EXEC or an auto-clear, holds at the limit when
  // the buffer is already empty so it never wraps.
  always_ff @(posedge clk) begin
    if (rst)                         idle_cnt <= 32'd0;
    else if (state == EXEC)          idle_cnt <= 32'd0;
    else if (timeout_hit)            idle_cnt <= 32'd0;
    else if (idle_cnt != TIMEOUT_CYC) idle_cnt <= idle_cnt + 32'd1;
  end
`else
  // No idle timer in this build; the parameter has no effect.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYC == 32'd0);
`endif

  // Entry buffer, key execution and commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_digits  <= 24'd0;
      n         <= 3'd0;
      o_key_vld <= 1'b0;
      o_key     <= 4'd0;
      o_value   <= 24'd0;
      o_enter   <= 1'b0;
    end else begin
      o_key_vld <= 1'b0;
      o_enter   <= 1'b0;
      if (state == EXEC) begin
        o_key_vld <= 1'b1;
        o_key     <= key_q;
        if (key_q <= 4'd9) begin
          if (n < 3'd6) begin
            o_digits <= {o_digits[19:0], key_q};
            n        <= n + 3'd1;
          end
        end else if (key_q == KEY_BS) begin
          if (n != 3'd0) begin
            o_digits <= {4'd0, o_digits[23:4]};
            n        <= n - 3'd1;
          end
        end else if (key_q == KEY_CLR) begin
          o_digits <= 24'd0;
          n        <= 3'd0;
        end else begin
          o_value  <= o_digits;
          o_enter  <= 1'b1;
          o_digits <= 24'd0;
          n        <= 3'd0;
        end
      end else if (timeout_hit) begin
        o_digits <= 24'd0;
        n        <= 3'd0;
      end
    end
  end

  // Next entry position marker; empty when the buffer is full.
  always_comb begin
    o_dp = 6'd0;
    if (n < 3'd6) o_dp = 6'd1 << n;
  end

endmodule
